// File: rtl/cordic_vec_arbiter.sv
// Round-robin sequencer sharing one pipelined CORDIC vectoring unit among requesters.
// Optional per-requester grant counters: define CORDIC_ARB_STATS_EN.
module cordic_vec_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int LATENCY    = 34,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_x,
    input  logic [NUM_REQ*32-1:0] req_y,
    output logic [31:0]           cord_x,
    output logic [31:0]           cord_y,
    output logic [31:0]           cord_z,
    input  logic [31:0]           cord_xn,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
`ifdef CORDIC_ARB_STATS_EN
    input  logic                  stat_clr,
    output logic [NUM_REQ*16-1:0] stat_grants,
`endif
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [ID_W-1:0]    ptr;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               pop;
    logic               can_issue;
    logic               found;
    logic               issue;
    logic               wr_en;
    logic [ID_W-1:0]    grant_id;
    logic [LATENCY-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [LATENCY];
    logic [31:0]        fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]    fifo_id [FIFO_DEPTH];

    assign pop   = rsp_valid & rsp_ready & ~flush;
    assign wr_en = tag_v[LATENCY-1] & ~flush;

    // A pop this edge frees one credit, so a full count may still issue.
    assign can_issue = ~RST & ~flush
                     & ((outstanding < CW'(FIFO_DEPTH)) | pop);
    assign issue = found & can_issue;

    always_comb begin
        logic [ID_W:0] j;
        j        = '0;
        found    = 1'b0;
        grant_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = {1'b0, ptr} + (ID_W+1)'(k);
            if (j >= (ID_W+1)'(NUM_REQ)) begin
                j = j - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[j[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = j[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ptr    <= ID_W'(NUM_REQ - 1);
            cord_x <= '0;
            cord_y <= '0;
        end else if (issue) begin
            ptr    <= grant_id;
            cord_x <= req_x[32*grant_id +: 32];
            cord_y <= req_y[32*grant_id +: 32];
        end
    end

    assign cord_z = '0;

    // Tag line tracks which requester owns each CORDIC pipeline slot.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else if (flush) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[LATENCY-2:0], issue};
            tag_id[0] <= issue ? grant_id : '0;
            for (int i = 1; i < LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_data[wr_ptr] <= cord_xn;
            fifo_id[wr_ptr]   <= tag_id[LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rsp_valid = (count != '0);
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            outstanding <= '0;
        end else if (flush) begin
            outstanding <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign busy = (outstanding != '0);

    // Credits make this unreachable; a hit means the accounting is broken.
    assert property (@(posedge clk) disable iff (RST)
        !(wr_en && (count == CW'(FIFO_DEPTH)) && !pop))
        else $error("response FIFO overflow");

`ifdef CORDIC_ARB_STATS_EN
    logic [15:0] grants [NUM_REQ];

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants[i] <= '0;
            end
        end else if (issue && (grants[grant_id] != 16'hFFFF)) begin
            grants[grant_id] <= grants[grant_id] + 16'd1;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[16*i +: 16] = grants[i];
        end
    end
`endif

endmodule
